// File: rtl/imem_program_encoder_pkg.sv
// Shared definitions for the instruction-memory program encoder.
//   - enc_op_e    : symbolic op select codes accepted on in_op (11..15 are invalid)
//   - OPCODE_*/FUNC_* : MIPS opcode / function fields, the same values control_unit decodes
//   - HALT_WORD   : beq $0,$0,-1, appended after a program when IMEM_ENCODER_HALT_WORD_EN is defined
//   - enc_state_e : load FSM states
//   - r_type/i_type : field packing helpers
package imem_program_encoder_pkg;

    typedef enum logic [3:0] {
        ENC_OP_ADD  = 4'd0,
        ENC_OP_AND  = 4'd1,
        ENC_OP_SUB  = 4'd2,
        ENC_OP_XOR  = 4'd3,
        ENC_OP_JR   = 4'd4,
        ENC_OP_NOP  = 4'd5,
        ENC_OP_ADDI = 4'd6,
        ENC_OP_ANDI = 4'd7,
        ENC_OP_BEQ  = 4'd8,
        ENC_OP_SW   = 4'd9,
        ENC_OP_LW   = 4'd10
    } enc_op_e;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;
    localparam logic [5:0] OPCODE_LW    = 6'h23;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_XOR = 6'h26;
    localparam logic [5:0] FUNC_JR  = 6'h08;

    localparam logic [31:0] HALT_WORD = 32'h1000_FFFF;

    // FLUSH: final word visible on the write port; HALT: halt word visible.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HALT  = 3'd3,
        ST_DONE  = 3'd4
    } enc_state_e;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] func);
        return {OPCODE_RTYPE, rs, rt, rd, 5'b0, func};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opcode, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imem_program_encoder_inst_word_encoder.sv
// inst_word_encoder: combinational op + fields -> 32-bit MIPS word.
// Ports:
//   op       in  4   enc_op_e select
//   rs/rt/rd in  5   register fields (unused ones ignored)
//   imm      in  16  immediate / branch word offset
//   word     out 32  encoded instruction (0 when op is invalid)
//   valid_op out 1   op is one of the defined codes
module inst_word_encoder
    import imem_program_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        valid_op
);

    always_comb begin
        word     = '0;
        valid_op = 1'b1;
        case (op)
            ENC_OP_ADD:  word = r_type(rs, rt, rd, FUNC_ADD);
            ENC_OP_AND:  word = r_type(rs, rt, rd, FUNC_AND);
            ENC_OP_SUB:  word = r_type(rs, rt, rd, FUNC_SUB);
            ENC_OP_XOR:  word = r_type(rs, rt, rd, FUNC_XOR);
            ENC_OP_JR:   word = r_type(rs, 5'd0, 5'd0, FUNC_JR);
            ENC_OP_NOP:  word = '0;
            ENC_OP_ADDI: word = i_type(OPCODE_ADDI, rs, rt, imm);
            ENC_OP_ANDI: word = i_type(OPCODE_ANDI, rs, rt, imm);
            ENC_OP_BEQ:  word = i_type(OPCODE_BEQ, rs, rt, imm);
            ENC_OP_SW:   word = i_type(OPCODE_SW, rs, rt, imm);
            ENC_OP_LW:   word = i_type(OPCODE_LW, rs, rt, imm);
            default:     valid_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/imem_program_encoder.sv
// imem_program_encoder: accepts symbolic instructions over valid/ready, encodes them
// and writes them sequentially into instruction memory starting at BASE_ADDR.
// Ports:
//   clk, reset (sync, active-high), start (begin a load)
//   in_valid/in_ready handshake; in_op, in_rs, in_rt, in_rd, in_imm, in_last instruction fields
//   im_write_enable/im_write_addr/im_write_data : registered memory write port
//   word_count : words written in the current/last load
//   done       : load complete, held until next start
//   err_invalid_op : sticky, an undefined in_op was received during this load
// Optional feature macro: IMEM_ENCODER_HALT_WORD_EN appends a halt word (beq $0,$0,-1)
// after the program when a slot is free.
module imem_program_encoder
    import imem_program_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic                  in_last,
    output logic                  im_write_enable,
    output logic [ADDR_WIDTH-1:0] im_write_addr,
    output logic [31:0]           im_write_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  done,
    output logic                  err_invalid_op
);

    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
`ifdef IMEM_ENCODER_HALT_WORD_EN
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
`endif

    enc_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic                  err_q, err_d;

    logic [31:0]           enc_word;
    logic                  enc_valid;
    logic [ADDR_WIDTH-1:0] slot_addr;

    inst_word_encoder u_enc (
        .op       (in_op),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .word     (enc_word),
        .valid_op (enc_valid)
    );

    // wc_q counts words already issued to the write register, so it is also the slot index.
    assign slot_addr = BASE_A + wc_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        wc_d    = wc_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    wc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (enc_valid) begin
                        we_d   = 1'b1;
                        addr_d = slot_addr;
                        data_d = enc_word;
                        wc_d   = wc_q + 1'b1;
                        // last slot filled ends the load even without in_last
                        if (in_last || wc_q == LAST_CNT) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (in_last) begin
`ifdef IMEM_ENCODER_HALT_WORD_EN
                            // still in LOAD, so a slot is always free here
                            we_d    = 1'b1;
                            addr_d  = slot_addr;
                            data_d  = HALT_WORD;
                            wc_d    = wc_q + 1'b1;
                            state_d = ST_HALT;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
            ST_FLUSH: begin
`ifdef IMEM_ENCODER_HALT_WORD_EN
                if (wc_q < DEPTH_CNT) begin
                    we_d    = 1'b1;
                    addr_d  = slot_addr;
                    data_d  = HALT_WORD;
                    wc_d    = wc_q + 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_HALT: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_A;
            data_q  <= '0;
            wc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
        end
    end

    assign in_ready        = (state_q == ST_LOAD);
    assign done            = (state_q == ST_DONE);
    assign im_write_enable = we_q;
    assign im_write_addr   = addr_q;
    assign im_write_data   = data_q;
    assign word_count      = wc_q;
    assign err_invalid_op  = err_q;

endmodule

// File: tb/tb_imem_program_encoder.sv
module tb_imem_program_encoder;

`ifdef IMEM_ENCODER_HALT_WORD_EN
    localparam int HALT_N = 1;
`else
    localparam int HALT_N = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;

    logic        ready0, we0, done0, err0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic [8:0]  wc0;
    logic        ready1, we1, done1, err1;
    logic [7:0]  addr1;
    logic [31:0] data1;
    logic [8:0]  wc1;

    imem_program_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0), .DEPTH(256)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .in_valid(valid0), .in_ready(ready0),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .im_write_enable(we0), .im_write_addr(addr0),
        .im_write_data(data0), .word_count(wc0), .done(done0), .err_invalid_op(err0)
    );

    imem_program_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(valid1), .in_ready(ready1),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .im_write_enable(we1), .im_write_addr(addr1),
        .im_write_data(data1), .word_count(wc1), .done(done1), .err_invalid_op(err1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoding, written from the MIPS field layout.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [4:0] d,
                                          input logic [15:0] im);
        case (op)
            4'd0:    return {1'b1, 6'h00, s, t, d, 5'h00, 6'h20};
            4'd1:    return {1'b1, 6'h00, s, t, d, 5'h00, 6'h24};
            4'd2:    return {1'b1, 6'h00, s, t, d, 5'h00, 6'h22};
            4'd3:    return {1'b1, 6'h00, s, t, d, 5'h00, 6'h26};
            4'd4:    return {1'b1, 6'h00, s, 10'h000, 5'h00, 6'h08};
            4'd5:    return {1'b1, 32'h0000_0000};
            4'd6:    return {1'b1, 6'h08, s, t, im};
            4'd7:    return {1'b1, 6'h0C, s, t, im};
            4'd8:    return {1'b1, 6'h04, s, t, im};
            4'd9:    return {1'b1, 6'h2B, s, t, im};
            4'd10:   return {1'b1, 6'h23, s, t, im};
            default: return {1'b0, 32'h0000_0000};
        endcase
    endfunction

    logic [39:0] exp0[$];
    logic [39:0] exp1[$];
    logic [39:0] e0, e1;
    int next_addr0 = 0;
    int next_addr1 = 0;

    // Scoreboard: every write strobe pops the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (we0) begin
            if (exp0.size() == 0) begin
                check_eq("dut0_unexpected_write", 64'(we0), 64'd0);
            end else begin
                e0 = exp0.pop_front();
                check_eq("dut0_wr_addr", 64'(addr0), 64'(e0[39:32]));
                check_eq("dut0_wr_data", 64'(data0), 64'(e0[31:0]));
            end
        end
        if (we1) begin
            if (exp1.size() == 0) begin
                check_eq("dut1_unexpected_write", 64'(we1), 64'd0);
            end else begin
                e1 = exp1.pop_front();
                check_eq("dut1_wr_addr", 64'(addr1), 64'(e1[39:32]));
                check_eq("dut1_wr_data", 64'(data1), 64'(e1[31:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) begin start0 = 1'b1; next_addr0 = 0; end
        else begin start1 = 1'b1; next_addr1 = 0; end
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Presents one instruction, waits (bounded) for in_ready, completes the transfer.
    task automatic send(input int sel, input logic [3:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
                        input logic last);
        logic [32:0] m;
        logic        rdy;
        logic        ok;
        in_op = op; in_rs = s; in_rt = t; in_rd = d; in_imm = im; in_last = last;
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        ok = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = (sel == 0) ? ready0 : ready1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            check_eq("ready_timeout", 64'(rdy), 64'd1);
        end else begin
            m = model(op, s, t, d, im);
            if (m[32]) begin
                if (sel == 0) begin
                    exp0.push_back({8'(next_addr0), m[31:0]});
                    next_addr0++;
                end else begin
                    exp1.push_back({8'(next_addr1), m[31:0]});
                    next_addr1++;
                end
            end
            step();
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        in_last = 1'b0;
    endtask

    // Called right after the final valid transfer of a dut0 load.
    task automatic finish_load0(input string tag);
`ifdef IMEM_ENCODER_HALT_WORD_EN
        exp0.push_back({8'(next_addr0), 32'h1000_FFFF});
        next_addr0++;
`endif
        check_eq({tag, "_done_early"}, 64'(done0), 64'd0);
        check_eq({tag, "_ready_low"}, 64'(ready0), 64'd0);
        repeat (1 + HALT_N) step();
        check_eq({tag, "_done"}, 64'(done0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(ready0), 64'd0);
        check_eq("rst_we", 64'(we0), 64'd0);
        check_eq("rst_addr", 64'(addr0), 64'd0);
        check_eq("rst_data", 64'(data0), 64'd0);
        check_eq("rst_wc", 64'(wc0), 64'd0);
        check_eq("rst_done", 64'(done0), 64'd0);
        check_eq("rst_err", 64'(err0), 64'd0);
        reset = 1'b0;
        step();
        check_eq("idle_ready", 64'(ready0), 64'd0);

        // Load A: ADD, invalid op mid-stream, then ADDI/LW/SW/JR(last)
        pulse_start(0);
        check_eq("load_ready", 64'(ready0), 64'd1);
        send(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        check_eq("ready_held", 64'(ready0), 64'd1);
        check_eq("add_data", 64'(data0), 64'h0022_1820);
        send(0, 4'd12, 5'd4, 5'd5, 5'd6, 16'h1234, 1'b0);
        check_eq("inv_err", 64'(err0), 64'd1);
        check_eq("inv_no_write", 64'(we0), 64'd0);
        check_eq("inv_wc", 64'(wc0), 64'd1);
        send(0, 4'd6, 5'd0, 5'd5, 5'd0, 16'd7, 1'b0);
        send(0, 4'd10, 5'd29, 5'd8, 5'd0, 16'd4, 1'b0);
        send(0, 4'd9, 5'd29, 5'd9, 5'd0, 16'd8, 1'b0);
        send(0, 4'd4, 5'd31, 5'd0, 5'd0, 16'h0, 1'b1);
        finish_load0("loadA");
        check_eq("loadA_wc", 64'(wc0), 64'(5 + HALT_N));
        check_eq("loadA_err_sticky", 64'(err0), 64'd1);

        // Load B: the four-instruction program from address 0
        pulse_start(0);
        check_eq("restart_err_clr", 64'(err0), 64'd0);
        check_eq("restart_done_clr", 64'(done0), 64'd0);
        check_eq("restart_wc_clr", 64'(wc0), 64'd0);
        send(0, 4'd6, 5'd0, 5'd5, 5'd0, 16'd7, 1'b0);
        check_eq("b_addi", 64'(data0), 64'h2005_0007);
        send(0, 4'd10, 5'd29, 5'd8, 5'd0, 16'd4, 1'b0);
        check_eq("b_lw", 64'(data0), 64'h8FA8_0004);
        send(0, 4'd9, 5'd29, 5'd9, 5'd0, 16'd8, 1'b0);
        check_eq("b_sw", 64'(data0), 64'hAFA9_0008);
        send(0, 4'd4, 5'd31, 5'd0, 5'd0, 16'h0, 1'b1);
        check_eq("b_jr", 64'(data0), 64'h03E0_0008);
        check_eq("b_jr_addr", 64'(addr0), 64'd3);
        finish_load0("loadB");
        check_eq("loadB_wc", 64'(wc0), 64'(4 + HALT_N));

        // Load C: idle gaps, start pulsed mid-load, remaining op kinds
        pulse_start(0);
        begin
            logic [3:0] ops [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd0, 4'd6};
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) step();
                if (i == 3) begin
                    start0 = 1'b1;
                    step();
                    start0 = 1'b0;
                end
                send(0, ops[i], 5'($urandom), 5'($urandom), 5'($urandom),
                     (ops[i] == 4'd8) ? 16'hFFFE : 16'($urandom), i == 7);
            end
        end
        finish_load0("loadC");
        check_eq("loadC_wc", 64'(wc0), 64'(8 + HALT_N));

        // DEPTH=4 instance: fills without in_last, then refuses further input
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            send(1, 4'(6 + (i % 2)), 5'(i), 5'(i + 1), 5'd0, 16'(100 + i), 1'b0);
        end
        check_eq("full_ready_low", 64'(ready1), 64'd0);
        valid1 = 1'b1;
        in_op = 4'd0;
        repeat (4) step();
        valid1 = 1'b0;
        check_eq("full_done", 64'(done1), 64'd1);
        check_eq("full_wc", 64'(wc1), 64'd4);
        check_eq("full_last_addr", 64'(addr1), 64'd3);
        check_eq("full_ready_after", 64'(ready1), 64'd0);

        // Reset coinciding with a transfer: no write, everything back to reset values
        pulse_start(0);
        send(0, 4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 1'b0);
        send(0, 4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
        in_op = 4'd6; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'h55AA;
        valid0 = 1'b1;
        reset = 1'b1;
        step();
        valid0 = 1'b0;
        check_eq("rst2_we", 64'(we0), 64'd0);
        check_eq("rst2_addr", 64'(addr0), 64'd0);
        check_eq("rst2_data", 64'(data0), 64'd0);
        check_eq("rst2_wc", 64'(wc0), 64'd0);
        check_eq("rst2_err", 64'(err0), 64'd0);
        check_eq("rst2_ready", 64'(ready0), 64'd0);
        check_eq("rst2_done", 64'(done0), 64'd0);
        reset = 1'b0;
        repeat (2) step();
        check_eq("rst2_no_write", 64'(we0), 64'd0);

        check_eq("dut0_pending", 64'(exp0.size()), 64'd0);
        check_eq("dut1_pending", 64'(exp1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
